mac_dot_sequencer: RTL and testbench

MAC_DOT_SEQUENCER -- requirements
Module: mac_dot_sequencer

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_pair_fifo.sv | 54 +++++
 rtl/mac_dot_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product sequencer and its operand FIFO.
package mac_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam int unsigned DEF_MAC_LAT = 2;
    localparam int unsigned DEF_DEPTH   = 4;

endpackage

// File: rtl/mac_pair_fifo.sv
// Operand-pair FIFO: 64-bit entries {a, b}, power-of-two depth, occupancy out.
module mac_pair_fifo
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [63:0]                wdata_i,
    input  logic                       pop_i,
    output logic [63:0]                rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at DEPTH; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + 1'b1;
            end else if (pop_i && !push_i) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: buffers operand pairs, clears the external MAC,
// streams pairs into it, drains the pipeline and captures the accumulator.
module mac_dot_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned MAC_LAT = DEF_MAC_LAT,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic [31:0]      mac_x1,
    output logic [31:0]      mac_x2,
    output logic             mac_clr,
    input  logic [31:0]      mac_acc,
    output logic [31:0]      result,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNTW = $clog2(DEPTH) + 1;
    localparam int unsigned PW   = $clog2(MAC_LAT + 1) + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [LEN_W-1:0] iss_cnt_q, iss_cnt_d;
    logic [PW-1:0]    ph_q, ph_d;
    logic [31:0]      x1_q, x1_d;
    logic [31:0]      x2_q, x2_d;
    logic [31:0]      result_q, result_d;

    logic             push;
    logic             pop;
    logic [63:0]      fifo_rdata;
    logic [CNTW-1:0]  fifo_cnt;

    mac_pair_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .wdata_i ({in_a, in_b}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt)
    );

    // in_ready depends only on registered state and occupancy, never on pop.
    assign in_ready = ((state_q == S_CLEAR) || (state_q == S_RUN))
                      && (fifo_cnt < FULL_CNT) && (acc_cnt_q < len_q);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_RUN) && (iss_cnt_q != len_q) && (fifo_cnt != '0);

    assign mac_clr  = !rst || (state_q == S_CLEAR);
    assign mac_x1   = x1_q;
    assign mac_x2   = x2_q;
    assign result   = result_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            acc_cnt_q <= '0;
            iss_cnt_q <= '0;
            ph_q      <= '0;
            x1_q      <= FP_ZERO;
            x2_q      <= FP_ZERO;
            result_q  <= FP_ZERO;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            acc_cnt_q <= acc_cnt_d;
            iss_cnt_q <= iss_cnt_d;
            ph_q      <= ph_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            result_q  <= result_d;
        end
    end

    // Next-state logic; MAC operands default to zero so every non-issue cycle is a bubble.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        iss_cnt_d = iss_cnt_q;
        ph_d      = ph_q;
        x1_d      = FP_ZERO;
        x2_d      = FP_ZERO;
        result_d  = result_q;

        if (push) begin
            acc_cnt_d = acc_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = vec_len;
                    acc_cnt_d = '0;
                    iss_cnt_d = '0;
                    ph_d      = '0;
                    if (vec_len == '0) begin
                        result_d = FP_ZERO;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (ph_q == PW'(MAC_LAT)) begin
                    ph_d    = '0;
                    state_d = S_RUN;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_RUN: begin
                // The last operand is still on mac_x in the cycle the count matches,
                // so DRAIN starts with the bus already back at zero.
                if (iss_cnt_q == len_q) begin
                    ph_d    = '0;
                    state_d = S_DRAIN;
                end else if (pop) begin
                    x1_d      = fifo_rdata[63:32];
                    x2_d      = fifo_rdata[31:0];
                    iss_cnt_d = iss_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (ph_q == PW'(MAC_LAT - 1)) begin
                    result_d = mac_acc;
                    ph_d     = '0;
                    state_d  = S_DONE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer with a behavioural latency-MAC_LAT MAC.
module tb_mac_dot_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAC_LAT = 4;   // CLEAR lasts 5 cycles, long enough to fill the FIFO
    localparam int unsigned LEN_W   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a, in_b;
    logic [31:0]      mac_x1, mac_x2;
    logic             mac_clr;
    logic [31:0]      mac_acc;
    logic [31:0]      result;
    logic             busy, done;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    mac_dot_sequencer #(
        .DEPTH   (DEPTH),
        .MAC_LAT (MAC_LAT),
        .LEN_W   (LEN_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .vec_len  (vec_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .mac_x1   (mac_x1),
        .mac_x2   (mac_x2),
        .mac_clr  (mac_clr),
        .mac_acc  (mac_acc),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    // Single <-> double conversion for normal numbers and zero (enough for the vectors used).
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) return 0.0;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Behavioural MAC: product of mac_x at cycle c is in mac_acc from cycle c+MAC_LAT.
    real pipe [MAC_LAT-1];
    real acc_r = 0.0;
    always @(posedge clk) begin
        if (mac_clr) begin
            for (int k = 0; k < MAC_LAT - 1; k++) pipe[k] <= 0.0;
            acc_r <= 0.0;
        end else begin
            pipe[0] <= sp2r(mac_x1) * sp2r(mac_x2);
            for (int k = 1; k < MAC_LAT - 1; k++) pipe[k] <= pipe[k-1];
            acc_r <= acc_r + pipe[MAC_LAT-2];
        end
    end
    assign mac_acc = r2sp(acc_r);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 result=%h expected no done", result);
            end else begin
                exp_v = sb_q.pop_front();
                check("result", result, exp_v);
            end
        end
    end

    task automatic start_job(input logic [LEN_W-1:0] len, input logic [31:0] exp_v);
        start   = 1'b1;
        vec_len = len;
        sb_q.push_back(exp_v);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input int gap);
        int t = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("send_accept", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen_clr, seen_rdy, chk_full;
        int  n_done;

        rst = 1'b0; start = 1'b0; vec_len = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_busy",    {31'd0, busy},     32'd0);
        check("rst_done",    {31'd0, done},     32'd0);
        check("rst_ready",   {31'd0, in_ready}, 32'd0);
        check("rst_clr",     {31'd0, mac_clr},  32'd1);
        check("rst_x1",      mac_x1,            32'h0);
        check("rst_x2",      mac_x2,            32'h0);
        check("rst_result",  result,            32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_clr", {31'd0, mac_clr}, 32'd0);

        // 1*3 + 2*4 = 11.0
        start_job(16'd2, 32'h4130_0000);
        send(32'h3F80_0000, 32'h4040_0000, 0);
        send(32'h4000_0000, 32'h4080_0000, 0);
        wait_done(100);
        @(negedge clk);

        // zero length: done next cycle, no clear, never ready
        start   = 1'b1;
        vec_len = '0;
        sb_q.push_back(32'h0);
        seen_clr = mac_clr;
        seen_rdy = in_ready;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (mac_clr)  seen_clr = 1'b1;
            if (in_ready) seen_rdy = 1'b1;
            @(negedge clk);
        end
        check("zero_no_clr",   {31'd0, seen_clr}, 32'd0);
        check("zero_no_ready", {31'd0, seen_rdy}, 32'd0);

        // three 1*1 pairs with 2-cycle gaps -> bubbles in RUN, 3.0
        start_job(16'd3, 32'h4040_0000);
        for (int i = 0; i < 3; i++) send(32'h3F80_0000, 32'h3F80_0000, 2);
        wait_done(200);
        @(negedge clk);

        // 8 pairs of 1*2 with in_valid held: FIFO fills during CLEAR, 16.0
        start_job(16'd8, 32'h4180_0000);
        in_valid = 1'b1;
        in_a     = 32'h3F80_0000;
        in_b     = 32'h4000_0000;
        k        = 0;
        chk_full = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (k == DEPTH && !chk_full) begin
                check("full_ready_low", {31'd0, in_ready}, 32'd0);
                check("clear_x1_zero",  mac_x1,            32'h0);
                chk_full = 1'b1;
            end
            if (in_ready) k++;
            @(negedge clk);
        end
        check("extra_refused", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        check("accepted_8", k, 32'd8);
        wait_done(200);
        @(negedge clk);

        // start during RUN ignored: 2*2 + 3*1 = 7.0
        start_job(16'd2, 32'h40E0_0000);
        send(32'h4000_0000, 32'h4000_0000, 0);
        repeat (6) @(negedge clk);
        start   = 1'b1;
        vec_len = 16'd5;
        @(negedge clk);
        start   = 1'b0;
        check("busy_run", {31'd0, busy}, 32'd1);
        send(32'h4040_0000, 32'h3F80_0000, 0);
        wait_done(200);
        @(negedge clk);

        // reset mid-RUN: abandon, no done
        start   = 1'b1;
        vec_len = 16'd4;
        @(negedge clk);
        start = 1'b0;
        send(32'h3F80_0000, 32'h3F80_0000, 0);
        send(32'h3F80_0000, 32'h3F80_0000, 0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy",   {31'd0, busy},     32'd0);
        check("abort_done",   {31'd0, done},     32'd0);
        check("abort_ready",  {31'd0, in_ready}, 32'd0);
        check("abort_clr",    {31'd0, mac_clr},  32'd1);
        check("abort_x1",     mac_x1,            32'h0);
        check("abort_x2",     mac_x2,            32'h0);
        check("abort_result", result,            32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_clr_off", {31'd0, mac_clr}, 32'd0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", n_done, 32'd0);

        // back-to-back: 5*2 = 10.0, then 1*3 = 3.0 started right after done
        start_job(16'd1, 32'h4120_0000);
        send(32'h40A0_0000, 32'h4000_0000, 0);
        wait_done(100);
        @(negedge clk);
        start_job(16'd1, 32'h4040_0000);
        send(32'h3F80_0000, 32'h4040_0000, 0);
        wait_done(100);
        @(negedge clk);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
